// File: rtl/shift_pkg.sv
// rtl/shift_pkg.sv - op and FSM state encodings shared by seq_shifter and shift_step
package shift_pkg;
  localparam logic [1:0] OP_SLL = 2'b00;
  localparam logic [1:0] OP_SRL = 2'b01;
  localparam logic [1:0] OP_SRA = 2'b10;
  localparam logic [1:0] OP_ROL = 2'b11;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;
endpackage

// File: rtl/shift_step.sv
// rtl/shift_step.sv - combinational shift of a WIDTH-bit value by 0..STEP bits
// Rotate-left for OP_ROL exists only when SEQ_SHIFTER_ROTATE_EN is defined; otherwise OP_ROL acts as SLL.
module shift_step
  import shift_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int STEP  = 4,
  localparam int AW   = $clog2(STEP + 1)
) (
  input  logic [WIDTH-1:0] din,
  input  logic [1:0]       op,
  input  logic [AW-1:0]    amt,
  output logic [WIDTH-1:0] dout
);
`ifdef SEQ_SHIFTER_ROTATE_EN
  logic [2*WIDTH-1:0] dbl;

  // Upper half of a doubled word shifted left is the rotated value.
  always_comb begin
    dbl = {din, din} << amt;
  end
`endif

  always_comb begin
    dout = din << amt;
    case (op)
      OP_SRL: dout = din >> amt;
      OP_SRA: dout = $unsigned($signed(din) >>> amt);
`ifdef SEQ_SHIFTER_ROTATE_EN
      OP_ROL: dout = dbl[2*WIDTH-1:WIDTH];
`endif
      default: dout = din << amt;
    endcase
  end
endmodule

// File: rtl/seq_shifter.sv
// rtl/seq_shifter.sv - iterative SLL/SRL/SRA shifter, at most STEP bits per cycle, valid/ready on both sides
// Optional rotate-left on op=11 when SEQ_SHIFTER_ROTATE_EN is defined.
module seq_shifter
  import shift_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int STEP  = 4,
  localparam int SHW  = $clog2(WIDTH),
  localparam int AW   = $clog2(STEP + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] din,
  input  logic [SHW-1:0]   shamt,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             busy
);
  localparam logic [31:0] STEP_W = 32'(STEP);

  logic [1:0]       state;
  logic [1:0]       op_q;
  logic [SHW-1:0]   rem;
  logic [31:0]      rem_w;
  logic [AW-1:0]    step;
  logic [WIDTH-1:0] shifted;

  assign in_ready  = (state == ST_IDLE);
  assign out_valid = (state == ST_DONE);
  assign busy      = (state != ST_IDLE);

  // step = min(remaining, STEP); step never exceeds rem, so it fits back into SHW bits.
  assign rem_w = 32'(rem);
  assign step  = (rem_w < STEP_W) ? AW'(rem) : AW'(STEP);

  shift_step #(.WIDTH(WIDTH), .STEP(STEP)) u_step (
    .din  (result),
    .op   (op_q),
    .amt  (step),
    .dout (shifted)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= ST_IDLE;
      result <= '0;
      op_q   <= OP_SLL;
      rem    <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (in_valid) begin
            result <= din;
            op_q   <= op;
            rem    <= shamt;
            state  <= (shamt == '0) ? ST_DONE : ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          result <= shifted;
          rem    <= rem - SHW'(step);
          if (rem_w <= STEP_W) state <= ST_DONE;
        end
        ST_DONE: begin
          if (out_ready) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end
endmodule
